note_event_encoder: RTL and testbench

//  Turns the per-voice note slots produced by the note tracker back into a MIDI event stream.

---
 rtl/midi_pkg.sv | 33 +++
 rtl/midi_msg_serializer.sv | 55 +++++
 rtl/note_event_encoder.sv | 131 +++++++++++++
 tb/tb_note_event_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants, slot/state types and slot-code decoding for the note event encoder.
package midi_pkg;

   localparam logic [7:0] STATUS_NOTE_ON  = 8'h90;
   localparam logic [7:0] STATUS_NOTE_OFF = 8'h80;
   localparam logic [7:0] EMPTY_SLOT      = 8'h00;

   typedef logic [7:0] slot_t;

   typedef enum logic [2:0] {
      ENC_IDLE,
      ENC_SCAN_OFF,
      ENC_WAIT_OFF,
      ENC_SCAN_ON,
      ENC_WAIT_ON,
      ENC_COMMIT
   } enc_state_t;

   typedef enum logic [1:0] {
      SEND_IDLE,
      SEND_STATUS,
      SEND_NOTE,
      SEND_VEL
   } send_state_t;

   // {valid, note}: slot code is {note_value, octave}, midi = 12*octave + note_value.
   function automatic logic [7:0] slot_to_midi(input slot_t s);
      logic [7:0] m;
      m = 8'(s[3:0]) * 8'd12 + 8'(s[7:4]);
      slot_to_midi = {(s != EMPTY_SLOT) && (s[7:4] <= 4'd11) && (m <= 8'd127), m[6:0]};
   endfunction

endpackage

// File: rtl/midi_msg_serializer.sv
// Sends one latched 3-byte MIDI message over a byte valid/ready link; done marks the last accept.
module midi_msg_serializer
   import midi_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [23:0] msg,
   output logic [7:0]  data,
   output logic        valid,
   input  logic        ready,
   output logic        done
);

   send_state_t state, state_nx;
   logic [23:0] msg_r;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= SEND_IDLE;
         msg_r <= '0;
      end else begin
         state <= state_nx;
         if (start && state == SEND_IDLE) msg_r <= msg;
      end
   end

   always_comb begin
      state_nx = state;
      done     = 1'b0;
      case (state)
         SEND_IDLE:   if (start) state_nx = SEND_STATUS;
         SEND_STATUS: if (ready) state_nx = SEND_NOTE;
         SEND_NOTE:   if (ready) state_nx = SEND_VEL;
         SEND_VEL: if (ready) begin
            state_nx = SEND_IDLE;
            done     = 1'b1;
         end
         default:     state_nx = SEND_IDLE;
      endcase
   end

   assign valid = (state != SEND_IDLE);

   always_comb begin
      data = 8'h00;
      case (state)
         SEND_STATUS: data = msg_r[23:16];
         SEND_NOTE:   data = msg_r[15:8];
         SEND_VEL:    data = msg_r[7:0];
         default:     data = 8'h00;
      endcase
   end

endmodule

// File: rtl/note_event_encoder.sv
// Diffs each voice-slot snapshot against the committed set and streams Note-Off then Note-On
// messages for the differences, one slot examined per cycle.
module note_event_encoder
   import midi_pkg::*;
#(
   parameter int         NUM_VOICES = 5,
   parameter logic [3:0] CHANNEL    = 4'd0,
   parameter logic [7:0] VELOCITY   = 8'd64
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [NUM_VOICES-1:0][7:0]     notes_in,
   input  logic                           notes_valid_in,
   input  logic                           all_off_in,
   output logic [7:0]                     byte_out,
   output logic                           byte_valid_out,
   input  logic                           byte_ready_in,
   output logic                           busy_out,
   output logic                           dropped_out
);

   localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

   enc_state_t state, state_nx;
   logic [IW-1:0] idx, idx_nx;
   logic [NUM_VOICES-1:0][7:0] work, committed, pend, snap, scan_set, ref_set;
   logic pend_full, dropped, strobe, cap_direct, off_phase, last, hit, present, start, done;
   slot_t cur;
   logic [7:0] cm, status, data2;
   logic [23:0] msg;

   assign strobe = notes_valid_in | all_off_in;
   assign snap   = all_off_in ? '0 : notes_in;
   // A strobe in COMMIT with nothing pending is taken straight into the work register.
   assign cap_direct = strobe && (state == ENC_IDLE || (state == ENC_COMMIT && !pend_full));
   assign off_phase  = (state == ENC_SCAN_OFF) || (state == ENC_WAIT_OFF);
   assign last       = (idx == IW'(NUM_VOICES - 1));

   always_comb begin
      scan_set = off_phase ? committed : work;
      ref_set  = off_phase ? work : committed;
      cur      = scan_set[idx];
      cm       = slot_to_midi(cur);
      present  = 1'b0;
      for (int k = 0; k < NUM_VOICES; k++) begin
         if (ref_set[k] == cur) present = 1'b1;
         if (k < int'(idx) && scan_set[k] == cur) present = 1'b1;
      end
      hit    = cm[7] && !present;
      status = (off_phase ? STATUS_NOTE_OFF : STATUS_NOTE_ON) | {4'h0, CHANNEL};
      data2  = off_phase ? 8'h00 : VELOCITY;
      msg    = {status, 1'b0, cm[6:0], data2};
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      start    = 1'b0;
      case (state)
         ENC_IDLE: if (strobe) begin
            state_nx = ENC_SCAN_OFF;
            idx_nx   = '0;
         end
         ENC_SCAN_OFF, ENC_WAIT_OFF: begin
            if (state == ENC_SCAN_OFF && hit) begin
               start    = 1'b1;
               state_nx = ENC_WAIT_OFF;
            end else if (state == ENC_SCAN_OFF || done) begin
               state_nx = last ? ENC_SCAN_ON : ENC_SCAN_OFF;
               idx_nx   = last ? '0 : idx + 1'b1;
            end
         end
         ENC_SCAN_ON, ENC_WAIT_ON: begin
            if (state == ENC_SCAN_ON && hit) begin
               start    = 1'b1;
               state_nx = ENC_WAIT_ON;
            end else if (state == ENC_SCAN_ON || done) begin
               state_nx = last ? ENC_COMMIT : ENC_SCAN_ON;
               idx_nx   = last ? '0 : idx + 1'b1;
            end
         end
         ENC_COMMIT: begin
            state_nx = (pend_full || strobe) ? ENC_SCAN_OFF : ENC_IDLE;
            idx_nx   = '0;
         end
         default: state_nx = ENC_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state     <= ENC_IDLE;
         idx       <= '0;
         work      <= '0;
         committed <= '0;
         pend      <= '0;
         pend_full <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         state   <= state_nx;
         idx     <= idx_nx;
         dropped <= 1'b0;
         if (state == ENC_COMMIT) committed <= work;
         if (cap_direct) work <= snap;
         else if (state == ENC_COMMIT && pend_full) work <= pend;
         if (strobe && !cap_direct) begin
            pend      <= snap;
            pend_full <= 1'b1;
            // In COMMIT the old pending snapshot moves to work, so it is not lost.
            dropped   <= pend_full && (state != ENC_COMMIT);
         end else if (state == ENC_COMMIT) begin
            pend_full <= 1'b0;
         end
      end
   end

   midi_msg_serializer u_ser (
      .clk   (clk_in),
      .rst   (rst_in),
      .start (start),
      .msg   (msg),
      .data  (byte_out),
      .valid (byte_valid_out),
      .ready (byte_ready_in),
      .done  (done)
   );

   assign busy_out    = (state != ENC_IDLE);
   assign dropped_out = dropped;

endmodule

// File: tb/tb_note_event_encoder.sv
// Randomized self-checking bench: a set-based MIDI diff model predicts the byte stream of two encoders.
module tb_note_event_encoder;

   localparam int NV = 5;

   logic clk_in = 1'b0;
   logic rst_in;
   logic [NV-1:0][7:0] notes_in;
   logic notes_valid_in, all_off_in, byte_ready_in;
   logic [7:0] byte_out, byte_out9;
   logic byte_valid_out, byte_valid9, busy_out, busy9, dropped_out, dropped9;

   always #5 clk_in = ~clk_in;

   note_event_encoder #(.NUM_VOICES(NV)) u_dut (
      .clk_in(clk_in), .rst_in(rst_in), .notes_in(notes_in), .notes_valid_in(notes_valid_in),
      .all_off_in(all_off_in), .byte_out(byte_out), .byte_valid_out(byte_valid_out),
      .byte_ready_in(byte_ready_in), .busy_out(busy_out), .dropped_out(dropped_out));

   note_event_encoder #(.NUM_VOICES(NV), .CHANNEL(4'd9)) u_ch9 (
      .clk_in(clk_in), .rst_in(rst_in), .notes_in(notes_in), .notes_valid_in(notes_valid_in),
      .all_off_in(all_off_in), .byte_out(byte_out9), .byte_valid_out(byte_valid9),
      .byte_ready_in(byte_ready_in), .busy_out(busy9), .dropped_out(dropped9));

   int checks = 0;
   int errors = 0;
   logic [7:0] exp0[$], exp1[$], got0[$], got1[$];
   logic [NV-1:0][7:0] model;
   int drop_cnt = 0, drop_cnt9 = 0;
   bit rmode = 0;
   bit rfix = 1;
   bit prev_stall = 0;
   logic [7:0] prev_byte = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      byte_ready_in = 1'b1;
      forever begin
         @(posedge clk_in);
         #1;
         byte_ready_in = rmode ? 1'($urandom_range(0, 1)) : rfix;
      end
   end

   // Inputs settle at posedge+1, so the negedge view is what the next rising edge will see.
   always @(negedge clk_in) begin
      if (rst_in) begin
         if (prev_stall) begin
            chk("hold_vld", byte_valid_out, 1);
            chk("hold_byte", byte_out, prev_byte);
         end
         if (byte_valid_out && byte_ready_in) got0.push_back(byte_out);
         if (byte_valid9 && byte_ready_in) got1.push_back(byte_out9);
         if (dropped_out) drop_cnt++;
         if (dropped9) drop_cnt9++;
         prev_stall = byte_valid_out && !byte_ready_in;
         prev_byte  = byte_out;
      end else begin
         prev_stall = 0;
      end
   end

   function automatic int to_midi(input logic [7:0] s);
      int nv, oc, m;
      if (s == 8'h00) return -1;
      nv = int'(s[7:4]);
      oc = int'(s[3:0]);
      if (nv > 11) return -1;
      m = 12 * oc + nv;
      if (m > 127) return -1;
      return m;
   endfunction

   function automatic bit in_list(input int a[NV], input int cnt, input int v);
      for (int k = 0; k < cnt; k++) if (a[k] == v) return 1;
      return 0;
   endfunction

   task automatic push_msg(input logic [7:0] st, input int m, input logic [7:0] vel);
      exp0.push_back(st);
      exp0.push_back(8'(m));
      exp0.push_back(vel);
      exp1.push_back(st | 8'h09);
      exp1.push_back(8'(m));
      exp1.push_back(vel);
   endtask

   task automatic add_diff(input logic [NV-1:0][7:0] o, input logic [NV-1:0][7:0] n);
      int om[NV], nm[NV];
      for (int i = 0; i < NV; i++) begin
         om[i] = to_midi(o[i]);
         nm[i] = to_midi(n[i]);
      end
      for (int i = 0; i < NV; i++)
         if (om[i] >= 0 && !in_list(nm, NV, om[i]) && !in_list(om, i, om[i]))
            push_msg(8'h80, om[i], 8'h00);
      for (int i = 0; i < NV; i++)
         if (nm[i] >= 0 && !in_list(om, NV, nm[i]) && !in_list(nm, i, nm[i]))
            push_msg(8'h90, nm[i], 8'h40);
   endtask

   task automatic cmp_streams(input string tag);
      chk({tag, "_n"}, got0.size(), exp0.size());
      for (int i = 0; i < exp0.size() && i < got0.size(); i++) chk({tag, "_b"}, got0[i], exp0[i]);
      chk({tag, "_n9"}, got1.size(), exp1.size());
      for (int i = 0; i < exp1.size() && i < got1.size(); i++) chk({tag, "_b9"}, got1[i], exp1[i]);
   endtask

   task automatic wait_idle(input string tag, output int cnt);
      cnt = 0;
      while ((busy_out || busy9) && cnt < 2000) begin
         cnt++;
         tick();
      end
      chk({tag, "_idle"}, busy_out, 0);
   endtask

   task automatic run_snap(input string tag, input logic [NV-1:0][7:0] s, input bit v, input bit o);
      logic [NV-1:0][7:0] nxt;
      int cnt;
      exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
      nxt = o ? '0 : s;
      add_diff(model, nxt);
      model = nxt;
      notes_in = s; notes_valid_in = v; all_off_in = o;
      tick();
      notes_valid_in = 0; all_off_in = 0;
      chk({tag, "_busy"}, busy_out, 1);
      wait_idle(tag, cnt);
      if (exp0.size() == 0) chk({tag, "_blen"}, cnt, 2 * NV + 1);
      cmp_streams(tag);
   endtask

   function automatic logic [7:0] rnd_slot();
      logic [7:0] pool[10];
      pool = '{8'h00, 8'h04, 8'h14, 8'h44, 8'h74, 8'hb3, 8'hc4, 8'ha8, 8'h0a, 8'h1a};
      if ($urandom_range(0, 7) == 0) return 8'($urandom);
      return pool[$urandom_range(0, 9)];
   endfunction

   initial begin
      logic [NV-1:0][7:0] a, b, c;
      int cnt, d0;
      rst_in = 0; notes_in = '0; notes_valid_in = 0; all_off_in = 0; model = '0;
      repeat (3) tick();
      chk("rst_vld", byte_valid_out, 0);
      chk("rst_byte", byte_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_drop", dropped_out, 0);
      rst_in = 1;
      tick();

      run_snap("c4_on", {8'h00, 8'h00, 8'h00, 8'h00, 8'h04}, 1, 0);
      run_snap("c4_off", '0, 1, 0);
      run_snap("two_on", {8'h00, 8'h00, 8'h00, 8'h74, 8'h04}, 1, 0);
      run_snap("move", {8'h00, 8'h00, 8'h00, 8'h44, 8'h74}, 1, 0);
      run_snap("dedup", {8'h00, 8'h00, 8'h00, 8'h04, 8'h04}, 1, 0);
      run_snap("bad_nv", {8'h00, 8'h00, 8'h00, 8'hc4, 8'h04}, 1, 0);
      run_snap("same", {8'h00, 8'h04, 8'h00, 8'h00, 8'h00}, 1, 0);
      run_snap("three", {8'h74, 8'h00, 8'h44, 8'h00, 8'h04}, 1, 0);
      run_snap("alloff", {8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 0, 1);
      run_snap("fill", {8'h00, 8'h0a, 8'h1a, 8'h00, 8'h00}, 1, 0);
      run_snap("both", {8'h12, 8'h00, 8'h00, 8'h00, 8'h00}, 1, 1);

      rmode = 1;
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < NV; i++) a[i] = rnd_slot();
         run_snap("rand", a, 1, 0);
      end

      // Capture A, then B and C while busy: B is overwritten by C.
      for (int i = 0; i < NV; i++) begin a[i] = rnd_slot(); b[i] = rnd_slot(); c[i] = rnd_slot(); end
      a[0] = 8'h57;
      exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
      add_diff(model, a);
      add_diff(a, c);
      model = c;
      d0 = drop_cnt;
      notes_in = a; notes_valid_in = 1; tick();
      notes_in = b; tick();
      notes_in = c; tick();
      notes_valid_in = 0;
      wait_idle("drop", cnt);
      chk("drop_cnt", drop_cnt - d0, 1);
      chk("drop_cnt9", drop_cnt9 - d0, 1);
      cmp_streams("drop");
      rmode = 0; rfix = 1;

      run_snap("pre_rst", {8'h00, 8'h00, 8'h00, 8'h00, 8'h44}, 1, 0);
      rfix = 0;
      repeat (2) tick();
      notes_in = {8'h00, 8'h00, 8'h00, 8'h00, 8'h74}; notes_valid_in = 1;
      tick();
      notes_valid_in = 0;
      cnt = 0;
      while (!byte_valid_out && cnt < 50) begin cnt++; tick(); end
      repeat (2) tick();
      chk("stall_vld", byte_valid_out, 1);
      rst_in = 0;
      tick();
      chk("mid_rst_vld", byte_valid_out, 0);
      chk("mid_rst_busy", busy_out, 0);
      tick();
      rst_in = 1; rfix = 1; model = '0;
      repeat (2) tick();
      run_snap("post_rst", {8'h00, 8'h00, 8'h00, 8'h00, 8'h04}, 1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
